// File: rtl/fetch_hold_ctrl.sv
// Front-end hold/redirect control: owns the fetch PC and the IF/ID register, reacts to the
// active-low load-use Stall and branch Flush, and keeps stall/flush counters plus a stuck-stall flag.
//
//   state  | meaning
//   RUN    | front end advancing or being redirected
//   HOLD   | Stall has held the front end for hold_len consecutive cycles
module fetch_hold_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16,
    parameter int              MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [XLEN-1:0]  Br_Target,
    input  logic [31:0]      Instr_F,
    output logic [XLEN-1:0]  PC_F,
    output logic [XLEN-1:0]  PC_D,
    output logic [31:0]      Instr_D,
    output logic             Valid_D,
    output logic             Bubble_E,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic             Stall_Err
);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [0:0]  S_RUN  = 1'b0;
    localparam logic [0:0]  S_HOLD = 1'b1;

    logic [XLEN-1:0]  pc_f_q, pc_f_d;
    logic [XLEN-1:0]  pc_d_q, pc_d_d;
    logic [31:0]      instr_d_q, instr_d_d;
    logic             valid_d_q, valid_d_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             err_q, err_d;
    logic [0:0]       state_q, state_d;
    logic [7:0]       hold_len_q, hold_len_d;
    logic             hold;

    // Flush wins over a simultaneous hold, so a flushed cycle never counts as a stall.
    assign hold = ~Stall & ~Flush;

    always_comb begin
        pc_f_d      = pc_f_q;
        pc_d_d      = pc_d_q;
        instr_d_d   = instr_d_q;
        valid_d_d   = valid_d_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        state_d     = state_q;
        hold_len_d  = hold_len_q;

        if (Flush) begin
            pc_f_d    = Br_Target;
            instr_d_d = NOP;
            valid_d_d = 1'b0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (hold) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            pc_f_d    = pc_f_q + XLEN'(4);
            pc_d_d    = pc_f_q;
            instr_d_d = Instr_F;
            valid_d_d = 1'b1;
        end

        case (state_q)
            S_RUN: begin
                if (hold) begin
                    state_d    = S_HOLD;
                    hold_len_d = 8'd1;
                end
            end
            default: begin
                if (hold) begin
                    if (hold_len_q != 8'hFF) hold_len_d = hold_len_q + 8'd1;
                    if (hold_len_q == 8'(MAX_HOLD)) err_d = 1'b1;
                end else begin
                    state_d    = S_RUN;
                    hold_len_d = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f_q      <= RESET_PC;
            pc_d_q      <= '0;
            instr_d_q   <= NOP;
            valid_d_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
            state_q     <= S_RUN;
            hold_len_q  <= 8'd0;
        end else begin
            pc_f_q      <= pc_f_d;
            pc_d_q      <= pc_d_d;
            instr_d_q   <= instr_d_d;
            valid_d_q   <= valid_d_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
            state_q     <= state_d;
            hold_len_q  <= hold_len_d;
        end
    end

    // Unknown Stall/Flush out of reset is a protocol violation by the stall unit.
    always @(posedge clk) begin
        if (rst) assert (!$isunknown({Stall, Flush}));
    end

    assign PC_F      = pc_f_q;
    assign PC_D      = pc_d_q;
    assign Instr_D   = instr_d_q;
    assign Valid_D   = valid_d_q;
    assign Bubble_E  = ~Stall | Flush;
    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
    assign Stall_Err = err_q;

endmodule
